// File: rtl/score_keeper.sv
// score_keeper: two-player point/set/match scorer fed by press-detector pulses; undo option via SCORE_UNDO_EN.
// Latency: one cycle from a sampled input pulse to the registered outputs.
// Backpressure: none; every pulse is consumed on the cycle it arrives.
module score_keeper #(
   parameter int WIN_POINTS  = 11,
   parameter int WIN_MARGIN  = 2,
   parameter int SETS_TO_WIN = 2,
   parameter int SCORE_W     = 6
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               p1_short_i,
   input  logic               p1_long_i,
   input  logic               p2_short_i,
   input  logic               p2_long_i,
   output logic [SCORE_W-1:0] p1_points_o,
   output logic [SCORE_W-1:0] p2_points_o,
   output logic [1:0]         p1_sets_o,
   output logic [1:0]         p2_sets_o,
   output logic [1:0]         state_o,
   output logic [1:0]         winner_o,
   output logic               set_won_o
);

   typedef enum logic [1:0] {
      PLAY       = 2'd0,
      SET_DONE   = 2'd1,
      MATCH_DONE = 2'd2
   } state_t;

   localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
   localparam logic [SCORE_W:0]   WIN_PTS_X  = (SCORE_W+1)'(WIN_POINTS);
   localparam logic [SCORE_W:0]   MARGIN_X   = (SCORE_W+1)'(WIN_MARGIN);
   localparam logic [1:0]         SETS_X     = 2'(SETS_TO_WIN);

   state_t             state_q, state_d;
   logic [SCORE_W-1:0] p1_pts_q, p1_pts_d, p2_pts_q, p2_pts_d;
   logic [1:0]         p1_sets_q, p1_sets_d, p2_sets_q, p2_sets_d;
   logic [1:0]         winner_q, winner_d;
   logic               set_won_q, set_won_d;
`ifdef SCORE_UNDO_EN
   logic               undo_vld_q, undo_vld_d;
   logic               undo_p2_q, undo_p2_d;
`endif

   // A long press masks shorts; two simultaneous shorts cancel each other.
   logic any_long, p1_pt, p2_pt, one_short;
   assign any_long  = p1_long_i | p2_long_i;
   assign p1_pt     = p1_short_i & ~p2_short_i & ~any_long;
   assign p2_pt     = p2_short_i & ~p1_short_i & ~any_long;
   assign one_short = p1_pt | p2_pt;

   logic [SCORE_W-1:0] scr_new, opp_pts;
   logic [SCORE_W:0]   lead;
   logic [1:0]         scr_sets_new;
   logic               set_award;

   always_comb begin
      scr_new      = p2_pt ? p2_pts_q + SCORE_W'(1) : p1_pts_q + SCORE_W'(1);
      opp_pts      = p2_pt ? p1_pts_q : p2_pts_q;
      lead         = {1'b0, scr_new} - {1'b0, opp_pts};
      scr_sets_new = (p2_pt ? p2_sets_q : p1_sets_q) + 2'd1;
      set_award    = (({1'b0, scr_new} >= WIN_PTS_X) && !lead[SCORE_W] && (lead >= MARGIN_X))
                   || (scr_new == SCORE_MAX);
   end

   always_comb begin
      state_d   = state_q;
      p1_pts_d  = p1_pts_q;
      p2_pts_d  = p2_pts_q;
      p1_sets_d = p1_sets_q;
      p2_sets_d = p2_sets_q;
      winner_d  = winner_q;
      set_won_d = 1'b0;
`ifdef SCORE_UNDO_EN
      undo_vld_d = undo_vld_q;
      undo_p2_d  = undo_p2_q;
`endif
      unique case (state_q)
         PLAY: begin
`ifdef SCORE_UNDO_EN
            if (any_long && undo_vld_q) begin
               if (undo_p2_q) begin
                  if (p2_pts_q != '0) p2_pts_d = p2_pts_q - SCORE_W'(1);
               end else begin
                  if (p1_pts_q != '0) p1_pts_d = p1_pts_q - SCORE_W'(1);
               end
               undo_vld_d = 1'b0;
            end
`endif
            if (one_short) begin
               if (p2_pt) p2_pts_d = scr_new;
               else       p1_pts_d = scr_new;
`ifdef SCORE_UNDO_EN
               undo_vld_d = ~set_award;
               undo_p2_d  = p2_pt;
`endif
               // Points stay frozen on award so the final score remains displayed.
               if (set_award) begin
                  set_won_d = 1'b1;
                  if (p2_pt) p2_sets_d = scr_sets_new;
                  else       p1_sets_d = scr_sets_new;
                  if (scr_sets_new == SETS_X) begin
                     state_d  = MATCH_DONE;
                     winner_d = p2_pt ? 2'b10 : 2'b01;
                  end else begin
                     state_d = SET_DONE;
                  end
               end
            end
         end
         SET_DONE: begin
            if (one_short) begin
               p1_pts_d = '0;
               p2_pts_d = '0;
               state_d  = PLAY;
            end
         end
         MATCH_DONE: begin
            if (any_long) begin
               p1_pts_d  = '0;
               p2_pts_d  = '0;
               p1_sets_d = '0;
               p2_sets_d = '0;
               winner_d  = '0;
               state_d   = PLAY;
`ifdef SCORE_UNDO_EN
               undo_vld_d = 1'b0;
               undo_p2_d  = 1'b0;
`endif
            end
         end
         default: state_d = PLAY;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= PLAY;
         p1_pts_q  <= '0;
         p2_pts_q  <= '0;
         p1_sets_q <= '0;
         p2_sets_q <= '0;
         winner_q  <= '0;
         set_won_q <= 1'b0;
`ifdef SCORE_UNDO_EN
         undo_vld_q <= 1'b0;
         undo_p2_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         p1_pts_q  <= p1_pts_d;
         p2_pts_q  <= p2_pts_d;
         p1_sets_q <= p1_sets_d;
         p2_sets_q <= p2_sets_d;
         winner_q  <= winner_d;
         set_won_q <= set_won_d;
`ifdef SCORE_UNDO_EN
         undo_vld_q <= undo_vld_d;
         undo_p2_q  <= undo_p2_d;
`endif
      end
   end

   assign p1_points_o = p1_pts_q;
   assign p2_points_o = p2_pts_q;
   assign p1_sets_o   = p1_sets_q;
   assign p2_sets_o   = p2_sets_q;
   assign state_o     = state_q;
   assign winner_o    = winner_q;
   assign set_won_o   = set_won_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed scenarios plus randomized pulses against a behavioural scoring model.
module tb_score_keeper;
   localparam int WP   = 11;
   localparam int WM   = 2;
   localparam int ST   = 2;
   localparam int SW   = 6;
   localparam int MAXP = (1 << SW) - 1;
`ifdef SCORE_UNDO_EN
   localparam bit UNDO_EN = 1'b1;
`else
   localparam bit UNDO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          p1s = 1'b0, p1l = 1'b0, p2s = 1'b0, p2l = 1'b0;
   logic [SW-1:0] p1_points, p2_points;
   logic [1:0]    p1_sets, p2_sets, state, winner;
   logic          set_won;

   int checks   = 0;
   int failures = 0;
   int won_seen = 0;

   // Reference model state: index 0 is player 1, index 1 is player 2.
   int m_pts[2];
   int m_sets[2];
   int m_st, m_win, m_won, m_uw;
   bit m_uv;

   score_keeper #(.WIN_POINTS(WP), .WIN_MARGIN(WM), .SETS_TO_WIN(ST), .SCORE_W(SW)) dut (
      .clk_i(clk), .rst_i(rst),
      .p1_short_i(p1s), .p1_long_i(p1l), .p2_short_i(p2s), .p2_long_i(p2l),
      .p1_points_o(p1_points), .p2_points_o(p2_points),
      .p1_sets_o(p1_sets), .p2_sets_o(p2_sets),
      .state_o(state), .winner_o(winner), .set_won_o(set_won)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      m_pts[0] = 0; m_pts[1] = 0; m_sets[0] = 0; m_sets[1] = 0;
      m_st = 0; m_win = 0; m_uv = 0; m_uw = 0;
   endtask

   task automatic model_step(input bit s1, input bit l1, input bit s2, input bit l2, input bit r);
      bit lng, one;
      int who, opp, sc;
      m_won = 0;
      if (r) begin
         model_clear();
         return;
      end
      lng = l1 || l2;
      one = (s1 != s2) && !lng;
      who = s1 ? 0 : 1;
      opp = 1 - who;
      case (m_st)
         0: begin
            if (lng) begin
               if (UNDO_EN && m_uv) begin
                  if (m_pts[m_uw] > 0) m_pts[m_uw] = m_pts[m_uw] - 1;
                  m_uv = 0;
               end
            end else if (one) begin
               m_pts[who] = m_pts[who] + 1;
               m_uv = 1;
               m_uw = who;
               sc   = m_pts[who];
               if ((sc >= WP && sc - m_pts[opp] >= WM) || sc == MAXP) begin
                  m_sets[who] = m_sets[who] + 1;
                  m_won = 1;
                  m_uv  = 0;
                  if (m_sets[who] == ST) begin
                     m_st  = 2;
                     m_win = who + 1;
                  end else begin
                     m_st = 1;
                  end
               end
            end
         end
         1: if (one) begin
            m_pts[0] = 0; m_pts[1] = 0; m_st = 0;
         end
         default: if (lng) model_clear();
      endcase
   endtask

   task automatic compare_all();
      check("p1_points", int'(p1_points), m_pts[0]);
      check("p2_points", int'(p2_points), m_pts[1]);
      check("p1_sets",   int'(p1_sets),   m_sets[0]);
      check("p2_sets",   int'(p2_sets),   m_sets[1]);
      check("state",     int'(state),     m_st);
      check("winner",    int'(winner),    m_win);
      check("set_won",   int'(set_won),   m_won);
   endtask

   task automatic cycle(input bit s1, input bit l1, input bit s2, input bit l2, input bit r);
      @(negedge clk);
      p1s = s1; p1l = l1; p2s = s2; p2l = l2; rst = r;
      @(posedge clk);
      model_step(s1, l1, s2, l2, r);
      #1;
      compare_all();
      if (set_won) won_seen++;
      p1s = 1'b0; p1l = 1'b0; p2s = 1'b0; p2l = 1'b0; rst = 1'b0;
   endtask

   task automatic score(input int who, input int n);
      for (int i = 0; i < n; i++) cycle(who == 0, 1'b0, who == 1, 1'b0, 1'b0);
   endtask

   task automatic expect_zero(input string tag);
      check({tag, "_p1pts"}, int'(p1_points), 0);
      check({tag, "_p2pts"}, int'(p2_points), 0);
      check({tag, "_p1sets"}, int'(p1_sets), 0);
      check({tag, "_p2sets"}, int'(p2_sets), 0);
      check({tag, "_state"}, int'(state), 0);
      check({tag, "_winner"}, int'(winner), 0);
      check({tag, "_setwon"}, int'(set_won), 0);
   endtask

   initial begin
      model_clear();
      m_won = 0;
      cycle(0, 0, 0, 0, 1);
      expect_zero("reset");

      // Straight set for player 1
      won_seen = 0;
      score(0, 11);
      check("ss_p1pts", int'(p1_points), 11);
      check("ss_p1sets", int'(p1_sets), 1);
      check("ss_state", int'(state), 1);
      cycle(0, 0, 0, 0, 0);
      check("ss_pulses", won_seen, 1);
      check("ss_hold_pts", int'(p1_points), 11);
      check("ss_setwon_low", int'(set_won), 0);
      cycle(0, 0, 1, 0, 0);
      check("sd_clear_p1", int'(p1_points), 0);
      check("sd_clear_p2", int'(p2_points), 0);
      check("sd_play", int'(state), 0);

      // Deuce: 10-10, 11-10, 11-11, 12-11, 13-11
      for (int i = 0; i < 10; i++) begin
         score(0, 1);
         score(1, 1);
      end
      score(0, 1);
      check("deuce_11_10", int'(state), 0);
      score(1, 1);
      score(0, 1);
      check("deuce_12_11", int'(state), 0);
      check("deuce_12_11_nopulse", int'(set_won), 0);
      score(0, 1);
      check("deuce_13_11_pts", int'(p1_points), 13);
      check("deuce_13_11_pulse", int'(set_won), 1);
      check("deuce_match_state", int'(state), 2);
      check("deuce_winner", int'(winner), 1);
      cycle(1, 0, 0, 0, 0);
      check("md_short_ignored", int'(p1_points), 13);
      cycle(1, 1, 0, 0, 0);
      expect_zero("restart1");

      // Simultaneous events and undo
      score(0, 1);
      cycle(1, 0, 1, 0, 0);
      check("both_short_p1", int'(p1_points), 1);
      check("both_short_p2", int'(p2_points), 0);
      score(1, 1); score(0, 1); score(1, 1); score(0, 1);
      check("pre_undo_p1", int'(p1_points), 3);
      check("pre_undo_p2", int'(p2_points), 2);
      cycle(0, 1, 1, 0, 0);
      check("undo1_p1", int'(p1_points), UNDO_EN ? 2 : 3);
      check("undo1_p2", int'(p2_points), 2);
      cycle(0, 0, 0, 1, 0);
      check("undo2_p1", int'(p1_points), UNDO_EN ? 2 : 3);
      check("undo2_p2", int'(p2_points), 2);
      cycle(1, 0, 0, 1, 1);
      expect_zero("reset2");

      // Match won by player 2
      score(1, 11);
      check("p2s1_state", int'(state), 1);
      cycle(1, 0, 0, 0, 0);
      score(1, 11);
      check("p2m_state", int'(state), 2);
      check("p2m_winner", int'(winner), 2);
      check("p2m_sets", int'(p2_sets), 2);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0);
      check("p2m_ign_p2", int'(p2_points), 11);
      check("p2m_ign_state", int'(state), 2);
      cycle(0, 0, 0, 1, 0);
      expect_zero("restart2");

      // Reset mid-match at 5-7, one set each
      score(0, 11); cycle(0, 0, 1, 0, 0);
      score(1, 11); cycle(1, 0, 0, 0, 0);
      score(0, 5); score(1, 7);
      check("mid_p1", int'(p1_points), 5);
      check("mid_p2", int'(p2_points), 7);
      check("mid_sets", int'(p1_sets) + int'(p2_sets), 2);
      cycle(0, 0, 0, 0, 1);
      expect_zero("midreset");
      score(0, 1);
      check("post_reset_p1", int'(p1_points), 1);
      check("post_reset_state", int'(state), 0);

      // Saturation award at 63-62
      cycle(0, 0, 0, 0, 1);
      for (int i = 0; i < MAXP - 1; i++) begin
         score(0, 1);
         score(1, 1);
      end
      check("sat_pre_state", int'(state), 0);
      score(0, 1);
      check("sat_p1pts", int'(p1_points), MAXP);
      check("sat_state", int'(state), 1);
      check("sat_pulse", int'(set_won), 1);

      // Randomized stream against the model
      for (int i = 0; i < 4000; i++) begin
         cycle($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 499) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
